mod_inverse_engine: RTL
=======================

Name: mod_inverse_engine

Overview:
- Iterative modular-inverse responder. Accepts (base, mod) over a valid/ready input channel and returns res = base^-1 mod mod over a valid/ready output channel.
- Serves as the arithmetic back end for Paillier key generation: it computes u = lambda^-1 mod n.
- Uses the binary extended Euclidean algorithm, one step per cycle, and flags non-invertible or illegal operands.

Parameters:
- DATA_WIDTH, 128, operand/result width in bits.
- CNT_WIDTH, 10, width of the iteration counter; must satisfy 2^CNT_WIDTH > 4*DATA_WIDTH+4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din_valid  input  1  initiator presents operands.
- din_ready  output  1  engine can accept operands.
- din_bits_base  input  DATA_WIDTH  value to invert.
- din_bits_mod  input  DATA_WIDTH  modulus.
- dout_valid  output  1  result available.
- dout_ready  input  1  initiator accepts result.
- dout_bits_res  output  DATA_WIDTH  inverse; 0 when dout_bits_err=1.
- dout_bits_err  output  1  operands illegal or gcd(base,mod)!=1.
- iter_count  output  CNT_WIDTH  number of ITER cycles used for the last/current job.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - din_ready=1, dout_valid=0, dout_bits_res=0, dout_bits_err=0, iter_count=0.
  - Internal u,v,x1,x2,m cleared.
- State IDLE:
  - din_ready=1 (combinational from state), dout_valid=0.
  - On din_valid&&din_ready, latch u=base, v=mod, m=mod, x1=1, x2=0, iter_count=0; go to CHECK.
- State CHECK (1 cycle): err=1 and go to DONE if any of:
  - m even,
  - m<3,
  - u==0,
  - u>=m.
  - Otherwise go to ITER.
- State ITER: one action per cycle, first matching rule wins; iter_count increments every ITER cycle.
  - 1) u==1: res=x1, err=0, go to DONE.
  - 2) v==1: res=x2, err=0, go to DONE.
  - 3) u==0 or v==0: res=0, err=1, go to DONE (gcd>1).
  - 4) u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+m)>>1.
  - 5) v even: v=v>>1; x2 same rule with m.
  - 6) u>=v: u=u-v; x1 = x1>=x2 ? x1-x2 : x1-x2+m.
  - 7) else: v=v-u; x2 = x2>=x1 ? x2-x1 : x2-x1+m.
- Width and range rules:
  - x+m is formed at DATA_WIDTH+1 bits before the shift, so there is no overflow.
  - x1 and x2 stay in [0,m) at all times.
  - Subtraction results are DATA_WIDTH bits.
- Safety bound: ITER terminates within 4*DATA_WIDTH+2 cycles. If iter_count reaches that bound, force err=1, res=0 and go to DONE; this never occurs for legal operands.
- State DONE:
  - dout_valid=1; dout_bits_res and dout_bits_err are registered and held stable while dout_ready=0.
  - din_ready=0.
  - On dout_ready=1, go to IDLE. dout_valid drops the next cycle; res/err hold their last value until the next result.
- Handshake:
  - din_valid may be asserted at any time; it is ignored outside IDLE.
  - A new job is never accepted in the same cycle as the output handshake completes.
- Latency: acceptance edge, then 1 CHECK cycle, then N ITER cycles, then dout_valid.
  - Minimum 2 cycles from acceptance to dout_valid (CHECK error path).
  - Minimum 3 cycles for base=1.
- Reset mid-operation: aborts the job immediately. No dout_valid is produced for the aborted job.

Test Plan:
- base=3, mod=7 -> dout_valid within 4*DATA_WIDTH+4 cycles, res=5, err=0; accept with dout_ready=1.
- base=24, mod=35 (lambda, n for p=5, q=7) -> res=19, err=0.
- base=5, mod=35 -> res=0, err=1 (gcd=5). Separately, base=3, mod=8 -> err=1, raised 2 cycles after acceptance (CHECK path).
- base=1, mod=1000003 -> res=1, err=0, iter_count=1. base=0 or base=mod -> err=1.
- Backpressure:
  - Hold dout_ready=0 for 10 cycles after dout_valid: res/err/dout_valid stay stable and din_ready=0.
  - A din_valid pulse during this window is not accepted.
  - Release dout_ready: din_ready=1 on the following cycle.
- Drop rst_n mid-ITER (base=24, mod=35): outputs return to reset values asynchronously. Restarting with base=3, mod=7 yields res=5.

Source files
------------

// File: rtl/mod_inverse_engine.sv
// Modular inverse res = base^-1 mod mod via binary extended Euclid, one step per cycle.
// Latency: accept, 1 CHECK cycle, N ITER cycles, then result held in DONE until dout_ready.
module mod_inverse_engine #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din_bits_base,
    input  logic [DATA_WIDTH-1:0] din_bits_mod,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_bits_res,
    output logic                  dout_bits_err,
    output logic [CNT_WIDTH-1:0]  iter_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_ITER  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_WIDTH-1:0]  ITER_LIMIT = CNT_WIDTH'(4 * DATA_WIDTH + 2);
    localparam logic [DATA_WIDTH-1:0] ZERO       = '0;
    localparam logic [DATA_WIDTH-1:0] ONE        = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] THREE      = DATA_WIDTH'(3);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] u_q, u_d, v_q, v_d;
    logic [DATA_WIDTH-1:0] x1_q, x1_d, x2_q, x2_d;
    logic [DATA_WIDTH-1:0] m_q, m_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    // Halving an odd coefficient adds m first; the sum needs one extra bit.
    logic [DATA_WIDTH:0]   x1_sum, x2_sum;
    logic [DATA_WIDTH-1:0] x1_half, x2_half;

    assign x1_sum  = {1'b0, x1_q} + {1'b0, m_q};
    assign x2_sum  = {1'b0, x2_q} + {1'b0, m_q};
    assign x1_half = x1_q[0] ? DATA_WIDTH'(x1_sum >> 1) : (x1_q >> 1);
    assign x2_half = x2_q[0] ? DATA_WIDTH'(x2_sum >> 1) : (x2_q >> 1);

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        m_d     = m_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    u_d     = din_bits_base;
                    v_d     = din_bits_mod;
                    m_d     = din_bits_mod;
                    x1_d    = ONE;
                    x2_d    = ZERO;
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (!m_q[0] || (m_q < THREE) || (u_q == ZERO) || (u_q >= m_q)) begin
                    res_d   = ZERO;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end

            S_ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q >= ITER_LIMIT) begin
                    res_d   = ZERO;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (u_q == ONE) begin
                    res_d   = x1_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (v_q == ONE) begin
                    res_d   = x2_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if ((u_q == ZERO) || (v_q == ZERO)) begin
                    // A zero remainder without reaching 1 means gcd(base, mod) > 1.
                    res_d   = ZERO;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = x1_half;
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = x2_half;
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = (x1_q >= x2_q) ? (x1_q - x2_q) : (x1_q - x2_q + m_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = (x2_q >= x1_q) ? (x2_q - x1_q) : (x2_q - x1_q + m_q);
                end
            end

            S_DONE: begin
                if (dout_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            m_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            m_q     <= m_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign din_ready     = (state_q == S_IDLE);
    assign dout_valid    = (state_q == S_DONE);
    assign dout_bits_res = res_q;
    assign dout_bits_err = err_q;
    assign iter_count    = cnt_q;

endmodule
